// File: rtl/ppu_mem_pkg.sv
// Shared types and decode helpers for the PPU-side VRAM mapper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ppu_mem_pkg;

    typedef enum logic [2:0] {
        MIR_HORIZ    = 3'd0,
        MIR_VERT     = 3'd1,
        MIR_SINGLE_A = 3'd2,
        MIR_SINGLE_B = 3'd3,
        MIR_FOUR     = 3'd4
    } mirror_mode_e;

    typedef enum logic [1:0] {
        REG_CHR,
        REG_NT,
        REG_PAL
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHR_WAIT,
        ST_RESP
    } chr_state_e;

    localparam logic [13:0] PAL_BASE = 14'h3F00;
    localparam logic [13:0] NT_BASE  = 14'h2000;

    function automatic region_e decode_region(input logic [13:0] a);
        region_e r;
        if (a >= PAL_BASE) begin
            r = REG_PAL;
        end else if (a >= NT_BASE) begin
            r = REG_NT;
        end else begin
            r = REG_CHR;
        end
        return r;
    endfunction

    // Unlisted modes, and four-screen without four pages, fall back to vertical.
    function automatic logic [1:0] nt_page(input logic [2:0] mode, input logic a11,
                                           input logic a10, input logic four_ok);
        logic [1:0] pg;
        case (mode)
            MIR_HORIZ:    pg = {1'b0, a11};
            MIR_SINGLE_A: pg = 2'd0;
            MIR_SINGLE_B: pg = 2'd1;
            MIR_FOUR:     pg = four_ok ? {a11, a10} : {1'b0, a10};
            default:      pg = {1'b0, a10};
        endcase
        return pg;
    endfunction

endpackage

// File: rtl/ppu_palette_ram.sv
// 32x6 palette register file with NES backdrop alias folding.
// Latency: write and read both take effect on the edge of the strobe; read data held until next read.
// Backpressure: none, accepts one access per cycle.
module ppu_palette_ram
    import ppu_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [4:0] idx,
    input  logic [5:0] wdata,
    output logic [7:0] rdata
);

    logic [5:0] mem [32];
    logic [4:0] fidx;

    // Sprite backdrop entries 0x10/0x14/0x18/0x1C share storage with 0x00/0x04/0x08/0x0C.
    assign fidx = (idx[1:0] == 2'b00) ? {1'b0, idx[3:0]} : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (wr_en) begin
                mem[fidx] <= wdata;
            end
            if (rd_en) begin
                rdata <= {2'b00, mem[fidx]};
            end
        end
    end

endmodule

// File: rtl/ppu_vram_mapper.sv
// PPU address decoder: CHR via external req/ack, internal mirrored nametable and palette RAM.
// Latency: nametable/palette/dropped CHR writes complete 1 cycle after accept; CHR waits for ack or timeout.
// Backpressure: busy high during a CHR access; req is ignored while busy.
module ppu_vram_mapper
    import ppu_mem_pkg::*;
#(
    parameter int NT_PAGES     = 2,
    parameter bit CHR_WRITABLE = 1'b0,
    parameter int CHR_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  mirror_mode,
    input  logic        req,
    input  logic        we,
    input  logic [13:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        chr_req,
    output logic        chr_we,
    output logic [12:0] chr_addr,
    output logic [7:0]  chr_wdata,
    input  logic [7:0]  chr_rdata,
    input  logic        chr_ack
);

    localparam int NT_AW   = $clog2(NT_PAGES * 1024);
    localparam int CW      = $clog2(CHR_TIMEOUT + 1);
    localparam bit FOUR_OK = (NT_PAGES == 4);

    chr_state_e       state_q, state_d;
    region_e          acc_region, rd_sel_q;
    logic             accept, chr_acc, fast_acc;
    logic             fast_done_q, err_q;
    logic             tmo_hit;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       page;
    logic [NT_AW-1:0] nt_idx;
    logic [7:0]       nt_mem [NT_PAGES * 1024];
    logic [7:0]       nt_rdata_q, chr_rdata_q, pal_rdata;
    logic             pal_wr, pal_rd;

    assign accept     = req && !busy;
    assign acc_region = decode_region(addr);
    assign chr_acc    = accept && (acc_region == REG_CHR) && (!we || CHR_WRITABLE);
    // Everything else, including dropped CHR writes, finishes one cycle after accept.
    assign fast_acc   = accept && !chr_acc;
    assign tmo_hit    = (state_q == ST_CHR_WAIT) && !chr_ack && (cnt_q == CW'(CHR_TIMEOUT - 1));

    assign page   = nt_page(mirror_mode, addr[11], addr[10], FOUR_OK);
    assign nt_idx = NT_AW'({page, addr[9:0]});

    always_ff @(posedge clk) begin
        if (fast_acc && (acc_region == REG_NT)) begin
            if (we) begin
                nt_mem[nt_idx] <= wdata;
            end else begin
                nt_rdata_q <= nt_mem[nt_idx];
            end
        end
    end

    assign pal_wr = fast_acc && (acc_region == REG_PAL) && we;
    assign pal_rd = fast_acc && (acc_region == REG_PAL) && !we;

    ppu_palette_ram u_pal (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (pal_wr),
        .rd_en (pal_rd),
        .idx   (addr[4:0]),
        .wdata (wdata[5:0]),
        .rdata (pal_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (chr_acc) state_d = ST_CHR_WAIT;
            ST_CHR_WAIT: if (chr_ack || tmo_hit) state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_RESP) || fast_done_q;
        err  = (state_q == ST_RESP) && err_q;
        case (rd_sel_q)
            REG_NT:  rdata = nt_rdata_q;
            REG_PAL: rdata = pal_rdata;
            default: rdata = chr_rdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fast_done_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            chr_req     <= 1'b0;
            chr_we      <= 1'b0;
            chr_addr    <= '0;
            chr_wdata   <= '0;
            chr_rdata_q <= '0;
            rd_sel_q    <= REG_CHR;
        end else begin
            fast_done_q <= fast_acc;
            if (chr_acc) begin
                chr_req   <= 1'b1;
                chr_we    <= we;
                chr_addr  <= addr[12:0];
                chr_wdata <= wdata;
                cnt_q     <= '0;
                err_q     <= 1'b0;
            end else if (state_q == ST_CHR_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (chr_ack) begin
                    chr_req <= 1'b0;
                    chr_we  <= 1'b0;
                    if (!chr_we) begin
                        chr_rdata_q <= chr_rdata;
                        rd_sel_q    <= REG_CHR;
                    end
                end else if (tmo_hit) begin
                    chr_req <= 1'b0;
                    chr_we  <= 1'b0;
                    err_q   <= 1'b1;
                    if (!chr_we) begin
                        chr_rdata_q <= 8'hFF;
                        rd_sel_q    <= REG_CHR;
                    end
                end
            end
            if (fast_acc && !we && (acc_region != REG_CHR)) begin
                rd_sel_q <= acc_region;
            end
        end
    end

endmodule

// File: tb/tb_ppu_vram_mapper.sv
// Bench for ppu_vram_mapper: dut_a is four-page with writable CHR, dut_b uses defaults.
// Both see the same stimulus; each has its own response scoreboard.
module tb_ppu_vram_mapper;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  mirror_mode;
    logic        req, we;
    logic [13:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  chr_rdata;
    logic        chr_ack;

    logic        busy_a, done_a, err_a, chr_req_a, chr_we_a;
    logic [7:0]  rdata_a, chr_wdata_a;
    logic [12:0] chr_addr_a;
    logic        busy_b, done_b, err_b, chr_req_b, chr_we_b;
    logic [7:0]  rdata_b, chr_wdata_b;
    logic [12:0] chr_addr_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;

    always #5 clk = ~clk;

    ppu_vram_mapper #(.NT_PAGES(4), .CHR_WRITABLE(1'b1), .CHR_TIMEOUT(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .mirror_mode(mirror_mode), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .busy(busy_a), .done(done_a), .rdata(rdata_a),
        .err(err_a), .chr_req(chr_req_a), .chr_we(chr_we_a), .chr_addr(chr_addr_a),
        .chr_wdata(chr_wdata_a), .chr_rdata(chr_rdata), .chr_ack(chr_ack)
    );

    ppu_vram_mapper dut_b (
        .clk(clk), .rst_n(rst_n), .mirror_mode(mirror_mode), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .busy(busy_b), .done(done_b), .rdata(rdata_b),
        .err(err_b), .chr_req(chr_req_b), .chr_we(chr_we_b), .chr_addr(chr_addr_b),
        .chr_wdata(chr_wdata_b), .chr_rdata(chr_rdata), .chr_ack(chr_ack)
    );

    // Scoreboards: every done must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n && done_a) begin
            n_cmp++;
            if (q_a.size() == 0) begin
                n_bad++;
                $display("FAIL resp_a_unexpected: done with rdata=%h err=%b, nothing pending", rdata_a, err_a);
            end else begin
                e_a = q_a.pop_front();
                if ({rdata_a, err_a} !== {e_a.data, e_a.err}) begin
                    n_bad++;
                    $display("FAIL resp_a: got rdata=%h err=%b, want rdata=%h err=%b", rdata_a, err_a, e_a.data, e_a.err);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && done_b) begin
            n_cmp++;
            if (q_b.size() == 0) begin
                n_bad++;
                $display("FAIL resp_b_unexpected: done with rdata=%h err=%b, nothing pending", rdata_b, err_b);
            end else begin
                e_b = q_b.pop_front();
                if ({rdata_b, err_b} !== {e_b.data, e_b.err}) begin
                    n_bad++;
                    $display("FAIL resp_b: got rdata=%h err=%b, want rdata=%h err=%b", rdata_b, err_b, e_b.data, e_b.err);
                end
            end
        end
    end

    // Drives one request at the falling edge; writes expect rdata to hold its last read value.
    task automatic issue(input logic w, input logic [13:0] a, input logic [7:0] d, input logic [2:0] m,
                         input logic [7:0] ea, input logic [7:0] eb, input logic e_err);
        exp_t x;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; mirror_mode = m;
        if (!w) begin
            last_a = ea;
            last_b = eb;
        end
        x.err = e_err;
        x.data = last_a;
        q_a.push_back(x);
        x.data = last_b;
        q_b.push_back(x);
    endtask

    task automatic idle;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        req = 0; we = 0; addr = '0; wdata = '0; mirror_mode = '0; chr_ack = 0; chr_rdata = '0;
        #12;
        n_cmp++;
        if ({busy_a, done_a, err_a, chr_req_a, chr_we_a, rdata_a, chr_addr_a, chr_wdata_a} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: busy=%b done=%b err=%b req=%b we=%b rdata=%h addr=%h wdata=%h, want all 0",
                     busy_a, done_a, err_a, chr_req_a, chr_we_a, rdata_a, chr_addr_a, chr_wdata_a);
        end
        n_cmp++;
        if ({busy_b, done_b, err_b, chr_req_b, chr_we_b, rdata_b, chr_addr_b, chr_wdata_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: busy=%b done=%b err=%b req=%b we=%b rdata=%h addr=%h wdata=%h, want all 0",
                     busy_b, done_b, err_b, chr_req_b, chr_we_b, rdata_b, chr_addr_b, chr_wdata_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mirroring;
        issue(1, 14'h2400, 8'h5C, 3'd1, 8'h00, 8'h00, 1'b0);
        issue(1, 14'h2000, 8'hA5, 3'd1, 8'h00, 8'h00, 1'b0);
        issue(0, 14'h2800, 8'h00, 3'd1, 8'hA5, 8'hA5, 1'b0);
        issue(0, 14'h2400, 8'h00, 3'd1, 8'h5C, 8'h5C, 1'b0);
        issue(0, 14'h2400, 8'h00, 3'd0, 8'hA5, 8'hA5, 1'b0);
        issue(0, 14'h2800, 8'h00, 3'd0, 8'h5C, 8'h5C, 1'b0);
        idle();
    endtask

    task automatic test_single_four;
        issue(1, 14'h2C05, 8'h3C, 3'd3, 8'h00, 8'h00, 1'b0);
        issue(0, 14'h2005, 8'h00, 3'd3, 8'h3C, 8'h3C, 1'b0);
        issue(1, 14'h2C05, 8'h77, 3'd2, 8'h00, 8'h00, 1'b0);
        issue(0, 14'h2405, 8'h00, 3'd2, 8'h77, 8'h77, 1'b0);
        issue(0, 14'h2005, 8'h00, 3'd3, 8'h3C, 8'h3C, 1'b0);
        // Four-screen: distinct pages on dut_a, vertical fallback on the two-page dut_b.
        issue(1, 14'h2000, 8'h11, 3'd4, 8'h00, 8'h00, 1'b0);
        issue(1, 14'h2400, 8'h22, 3'd4, 8'h00, 8'h00, 1'b0);
        issue(1, 14'h2800, 8'h33, 3'd4, 8'h00, 8'h00, 1'b0);
        issue(1, 14'h2C00, 8'h44, 3'd4, 8'h00, 8'h00, 1'b0);
        issue(0, 14'h2000, 8'h00, 3'd4, 8'h11, 8'h33, 1'b0);
        issue(0, 14'h2400, 8'h00, 3'd4, 8'h22, 8'h44, 1'b0);
        issue(0, 14'h2800, 8'h00, 3'd4, 8'h33, 8'h33, 1'b0);
        issue(0, 14'h2C00, 8'h00, 3'd4, 8'h44, 8'h44, 1'b0);
        issue(0, 14'h2800, 8'h00, 3'd5, 8'h11, 8'h33, 1'b0);
        issue(0, 14'h2C00, 8'h00, 3'd7, 8'h22, 8'h44, 1'b0);
        issue(0, 14'h3000, 8'h00, 3'd4, 8'h11, 8'h33, 1'b0);
        issue(0, 14'h3C00, 8'h00, 3'd4, 8'h44, 8'h44, 1'b0);
        idle();
    endtask

    task automatic test_palette;
        issue(0, 14'h3F05, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
        issue(1, 14'h3F10, 8'hFF, 3'd0, 8'h00, 8'h00, 1'b0);
        issue(0, 14'h3F00, 8'h00, 3'd0, 8'h3F, 8'h3F, 1'b0);
        issue(0, 14'h3F30, 8'h00, 3'd0, 8'h3F, 8'h3F, 1'b0);
        issue(1, 14'h3F11, 8'h2A, 3'd0, 8'h00, 8'h00, 1'b0);
        issue(0, 14'h3F01, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
        issue(0, 14'h3F11, 8'h00, 3'd0, 8'h2A, 8'h2A, 1'b0);
        issue(1, 14'h3F0C, 8'h95, 3'd0, 8'h00, 8'h00, 1'b0);
        issue(0, 14'h3F1C, 8'h00, 3'd0, 8'h15, 8'h15, 1'b0);
        issue(0, 14'h3FFC, 8'h00, 3'd0, 8'h15, 8'h15, 1'b0);
        idle();
    endtask

    task automatic test_chr_read;
        issue(0, 14'h1234, 8'h00, 3'd4, 8'h5A, 8'h5A, 1'b0);
        @(posedge clk); #1;
        // A nametable write presented while busy must be dropped.
        req = 1'b1; we = 1'b1; addr = 14'h2000; wdata = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({chr_req_a, busy_a, chr_we_a, chr_addr_a} !== {1'b1, 1'b1, 1'b0, 13'h1234} ||
                {chr_req_b, busy_b, chr_we_b, chr_addr_b} !== {1'b1, 1'b1, 1'b0, 13'h1234}) begin
                n_bad++;
                $display("FAIL chr_hold[%0d]: a req/busy/we/addr=%b%b%b/%h b=%b%b%b/%h, want 110/1234",
                         i, chr_req_a, busy_a, chr_we_a, chr_addr_a, chr_req_b, busy_b, chr_we_b, chr_addr_b);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        req = 1'b0; we = 1'b0;
        chr_ack = 1'b1; chr_rdata = 8'h5A;
        @(posedge clk); #1;
        chr_ack = 1'b0; chr_rdata = 8'h00;
        n_cmp++;
        if ({done_a, done_b, chr_req_a, chr_req_b} !== 4'b1100) begin
            n_bad++;
            $display("FAIL chr_done: done a/b=%b/%b chr_req a/b=%b/%b, want done=1 chr_req=0",
                     done_a, done_b, chr_req_a, chr_req_b);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done_a, done_b, busy_a, busy_b} !== 4'b0000) begin
            n_bad++;
            $display("FAIL chr_after: done a/b=%b/%b busy a/b=%b/%b, want all 0", done_a, done_b, busy_a, busy_b);
        end
        issue(0, 14'h2000, 8'h00, 3'd4, 8'h11, 8'h33, 1'b0);
        idle();
    endtask

    task automatic test_chr_timeout;
        int cnt = 0;
        int guard = 0;
        issue(0, 14'h0ABC, 8'h00, 3'd0, 8'hFF, 8'hFF, 1'b1);
        do begin
            @(posedge clk); #1;
            req = 1'b0;
            guard++;
            if (chr_req_a) cnt++;
        end while ((chr_req_a || cnt == 0) && guard < 40);
        n_cmp++;
        if (cnt != 15) begin
            n_bad++;
            $display("FAIL tmo_len: chr_req high %0d cycles, want 15", cnt);
        end
        n_cmp++;
        if ({done_a, err_a, done_b, err_b, chr_req_b} !== 5'b11110) begin
            n_bad++;
            $display("FAIL tmo_pulse: done/err a=%b%b b=%b%b chr_req_b=%b, want 11 11 0",
                     done_a, err_a, done_b, err_b, chr_req_b);
        end
        @(negedge clk);
        chr_ack = 1'b1; chr_rdata = 8'h99;
        repeat (2) @(negedge clk);
        chr_ack = 1'b0; chr_rdata = 8'h00;
        n_cmp++;
        if ({chr_req_a, busy_a, rdata_a, chr_req_b, busy_b, rdata_b} !== {2'b00, 8'hFF, 2'b00, 8'hFF}) begin
            n_bad++;
            $display("FAIL late_ack: a req/busy/rdata=%b%b/%h b=%b%b/%h, want 00/ff",
                     chr_req_a, busy_a, rdata_a, chr_req_b, busy_b, rdata_b);
        end
    endtask

    task automatic test_chr_write;
        issue(1, 14'h0100, 8'h6B, 3'd0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        n_cmp++;
        if ({chr_req_b, done_b, busy_b} !== 3'b010) begin
            n_bad++;
            $display("FAIL chrw_drop: b chr_req/done/busy=%b%b%b, want 010", chr_req_b, done_b, busy_b);
        end
        n_cmp++;
        if ({chr_req_a, chr_we_a, chr_addr_a, chr_wdata_a, busy_a} !== {2'b11, 13'h0100, 8'h6B, 1'b1}) begin
            n_bad++;
            $display("FAIL chrw_fwd: a req=%b we=%b addr=%h wdata=%h busy=%b, want 1 1 0100 6b 1",
                     chr_req_a, chr_we_a, chr_addr_a, chr_wdata_a, busy_a);
        end
        @(posedge clk); #1;
        chr_ack = 1'b1;
        @(posedge clk); #1;
        chr_ack = 1'b0;
        n_cmp++;
        if ({done_a, rdata_a, chr_req_b} !== {1'b1, 8'hFF, 1'b0}) begin
            n_bad++;
            $display("FAIL chrw_done: a done=%b rdata=%h b chr_req=%b, want 1 ff 0", done_a, rdata_a, chr_req_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        issue(0, 14'h0200, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        req = 1'b0;
        n_cmp++;
        if ({chr_req_a, chr_req_b} !== 2'b11) begin
            n_bad++;
            $display("FAIL rst_pre: chr_req a/b=%b/%b, want 1/1", chr_req_a, chr_req_b);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_a, done_a, err_a, chr_req_a, chr_we_a, rdata_a, chr_addr_a, chr_wdata_a,
             busy_b, done_b, err_b, chr_req_b, chr_we_b, rdata_b, chr_addr_b, chr_wdata_b} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: a busy=%b req=%b addr=%h rdata=%h b busy=%b req=%b addr=%h rdata=%h, want 0",
                     busy_a, chr_req_a, chr_addr_a, rdata_a, busy_b, chr_req_b, chr_addr_b, rdata_b);
        end
        q_a.delete();
        q_b.delete();
        last_a = 8'h00;
        last_b = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 14'h3F00, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
        issue(1, 14'h2123, 8'h4D, 3'd1, 8'h00, 8'h00, 1'b0);
        issue(0, 14'h2123, 8'h00, 3'd1, 8'h4D, 8'h4D, 1'b0);
        issue(0, 14'h1FFF, 8'h00, 3'd1, 8'hC3, 8'hC3, 1'b0);
        @(posedge clk); #1;
        req = 1'b0;
        chr_ack = 1'b1; chr_rdata = 8'hC3;
        n_cmp++;
        if ({chr_req_a, chr_addr_a, chr_req_b, chr_addr_b} !== {1'b1, 13'h1FFF, 1'b1, 13'h1FFF}) begin
            n_bad++;
            $display("FAIL rst_next: chr_req/addr a=%b/%h b=%b/%h, want 1/1fff", chr_req_a, chr_addr_a, chr_req_b, chr_addr_b);
        end
        @(posedge clk); #1;
        chr_ack = 1'b0; chr_rdata = 8'h00;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mirroring();
        test_single_four();
        test_palette();
        test_chr_read();
        test_chr_timeout();
        test_chr_write();
        test_reset_mid();
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending responses a=%0d b=%0d, want 0/0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
